// File: rtl/pulse_stretcher_mc.sv
// pulse_stretcher_mc: per-channel delayed, width-programmable pulse generator with one-shot/retrigger modes
module pulse_stretcher_mc #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_retrig,
  input  logic [NCH*CW-1:0] cfg_delay,
  input  logic [NCH*CW-1:0] cfg_width,
  input  logic [NCH-1:0]    trig_in,
  input  logic              clr_missed,
  output logic [NCH-1:0]    pulse_out,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    trig_missed
);
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;
  logic [NCH-1:0] r_trig_q;
  logic [NCH-1:0] w_rise;
  assign w_rise = trig_in & ~r_trig_q;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) r_trig_q <= '0;
    else r_trig_q <= trig_in;
  for (genvar g = 0; g < NCH; g++) begin : ch
    state_t        r_state;
    logic [CW-1:0] r_cnt, r_w;
    logic          r_pulse, r_busy, r_done, r_missed;
    logic [CW-1:0] w_d, w_wn;
    logic          w_miss;
    assign w_d  = cfg_delay[g*CW +: CW];
    assign w_wn = cfg_width[g*CW +: CW];
    // Drops: any rise while delaying, or while active in one-shot mode
    assign w_miss = enable & w_rise[g] & ((r_state == DELAY) | ((r_state == ACTIVE) & ~cfg_retrig));
    always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_w      <= '0;
        r_pulse  <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
        r_missed <= 1'b0;
      end else begin
        r_missed <= w_miss | (r_missed & ~clr_missed);
        if (!enable) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_w     <= '0;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end else begin
          r_done <= 1'b0;
          case (r_state)
            IDLE:
              if (w_rise[g] && w_wn != '0) begin
                r_busy  <= 1'b1;
                r_w     <= w_wn;
                r_state <= (w_d == '0) ? ACTIVE : DELAY;
                r_pulse <= (w_d == '0);
                r_cnt   <= (w_d == '0) ? w_wn : w_d;
              end
            DELAY:
              if (r_cnt == CW'(1)) begin
                r_state <= ACTIVE;
                r_pulse <= 1'b1;
                r_cnt   <= r_w;
              end else r_cnt <= r_cnt - 1'b1;
            ACTIVE:
              if (w_rise[g] && cfg_retrig && w_wn != '0) r_cnt <= w_wn;
              else if (r_cnt == CW'(1)) begin
                r_state <= IDLE;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_cnt   <= '0;
              end else r_cnt <= r_cnt - 1'b1;
            default: r_state <= IDLE;
          endcase
        end
      end
    assign pulse_out[g]   = r_pulse;
    assign busy[g]        = r_busy;
    assign done[g]        = r_done;
    assign trig_missed[g] = r_missed;
  end
endmodule
